// File: rtl/rpn_pkg.sv
// rpn_pkg: shared constants for the RPN stack controller.
//   - opcode values carried in tok_data when tok_is_op = 1
//   - error codes reported on err_code
//   - controller state encoding
package rpn_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_OUT = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_UNDER   = 2'b01;
    localparam logic [1:0] ERR_OVER    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_B,
        WAIT_B,
        POP_A,
        WAIT_A,
        PUSH_R,
        RES
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational binary operator for the RPN controller.
//   a  : deeper operand
//   b  : top-of-stack operand
//   op : opcode (ADD/SUB/AND/OR/XOR); anything else yields 0
//   y  : result, mod 2^W
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: token-driven reverse-Polish evaluator sitting in front of
// a DEPTH x W LIFO stack. Tracks stack occupancy itself so it never pushes
// into a full stack or pops an empty one.
//   clk, reset          : clock, synchronous active-high reset
//   tok_valid/tok_ready : token handshake; tok_is_op selects opcode vs operand
//   tok_data            : operand value or opcode
//   stk_push/stk_pop    : one-cycle strobes to the stack
//   stk_data_in         : value pushed; stk_data_out valid the cycle after a pop
//   res_valid/res_data  : result pulse, res_data held until the next result
//   err_valid/err_code  : error pulse, err_code held until the next error
//   depth               : current occupancy
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tok_valid,
    output logic          tok_ready,
    input  logic          tok_is_op,
    input  logic [W-1:0]  tok_data,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [W-1:0]  stk_data_in,
    input  logic [W-1:0]  stk_data_out,
    output logic          res_valid,
    output logic [W-1:0]  res_data,
    output logic          err_valid,
    output logic [1:0]    err_code,
    output logic [CW-1:0] depth
);

    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic [2:0]    op_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  opnd_q;
    logic [W-1:0]  alu_y;
    logic          accept;
    logic          tok_err;
    logic [1:0]    tok_err_code;

    assign tok_ready   = (state == IDLE);
    assign accept      = tok_valid & tok_ready;
    assign depth       = count;
    assign stk_push    = (state == PUSH) || (state == PUSH_R);
    assign stk_pop     = (state == POP_B) || (state == POP_A);
    assign res_valid   = (state == PUSH_R) || (state == RES);
    // Operand pushes come from the latched token, result pushes from res_data.
    assign stk_data_in = (state == PUSH_R) ? res_data : opnd_q;

    rpn_alu #(.W(W)) u_alu (
        .a  (stk_data_out),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_comb begin
        state_nx     = state;
        tok_err      = 1'b0;
        tok_err_code = ERR_NONE;
        case (state)
            IDLE: begin
                if (accept) begin
                    // All legality checks use count, which is stable in IDLE.
                    if (!tok_is_op) begin
                        if (count == CW'(DEPTH)) begin
                            tok_err      = 1'b1;
                            tok_err_code = ERR_OVER;
                        end else begin
                            state_nx = PUSH;
                        end
                    end else if (tok_data > W'(OP_OUT)) begin
                        tok_err      = 1'b1;
                        tok_err_code = ERR_ILLEGAL;
                    end else if (tok_data == W'(OP_OUT)) begin
                        if (count == '0) begin
                            tok_err      = 1'b1;
                            tok_err_code = ERR_UNDER;
                        end else begin
                            state_nx = POP_B;
                        end
                    end else if (count < CW'(2)) begin
                        tok_err      = 1'b1;
                        tok_err_code = ERR_UNDER;
                    end else begin
                        state_nx = POP_B;
                    end
                end
            end
            PUSH:    state_nx = IDLE;
            POP_B:   state_nx = WAIT_B;
            // OUT needs only the top value; binary ops go on to fetch A.
            WAIT_B:  state_nx = (op_q == OP_OUT) ? RES : POP_A;
            POP_A:   state_nx = WAIT_A;
            WAIT_A:  state_nx = PUSH_R;
            PUSH_R:  state_nx = IDLE;
            RES:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            res_data  <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_nx;
            err_valid <= tok_err;
            if (tok_err)
                err_code <= tok_err_code;
            if (accept && !tok_is_op)
                opnd_q <= tok_data;
            if (accept && tok_is_op)
                op_q <= tok_data[2:0];
            case (state)
                PUSH, PUSH_R: count <= count + CW'(1);
                POP_B, POP_A: count <= count - CW'(1);
                WAIT_B: begin
                    b_q <= stk_data_out;
                    if (op_q == OP_OUT)
                        res_data <= stk_data_out;
                end
                WAIT_A:  res_data <= alu_y;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
module tb_rpn_stack_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_is_op = 1'b0;
    logic [3:0] tok_data = 4'd0;
    logic       stk_push, stk_pop;
    logic [3:0] stk_data_in;
    logic [3:0] stk_data_out;
    logic       res_valid;
    logic [3:0] res_data;
    logic       err_valid;
    logic [1:0] err_code;
    logic [3:0] depth;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rpn_stack_ctrl #(.W(4), .DEPTH(8), .CW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .depth        (depth)
    );

    // 8 x 4 LIFO the controller drives; data_out registered on the pop edge.
    logic [3:0] smem [8];
    int sp;
    always @(posedge clk) begin
        if (reset) begin
            sp           <= 0;
            stk_data_out <= 4'd0;
        end else if (stk_push) begin
            if (sp < 8) begin
                smem[sp] <= stk_data_in;
                sp       <= sp + 1;
            end
        end else if (stk_pop) begin
            if (sp > 0) begin
                stk_data_out <= smem[sp-1];
                sp           <= sp - 1;
            end
        end
    end

    function automatic void chk(string nm, int got, int exp);
        ncmp++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endfunction

    // Stack-side protocol: strobes exclusive, no push when full, no pop when empty.
    always @(negedge clk) begin
        if (!reset && (stk_push || stk_pop)) begin
            chk("strobe_exclusive", int'(stk_push && stk_pop), 0);
            if (stk_push) chk("push_room", int'(sp < 8), 1);
            if (stk_pop)  chk("pop_avail", int'(sp > 0), 1);
        end
        if (!reset) begin
            if (int'(depth) != sp) chk("depth_vs_stack", int'(depth), sp);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one token (called at a negedge) and observe until tok_ready returns.
    // Cycle k = k-th rising edge after the accepting edge.
    task automatic run_tok(input bit is_op, input logic [3:0] d,
                           output int res_cyc, output logic [3:0] res_v,
                           output int err_cyc, output logic [1:0] err_c,
                           output int push_cnt, output logic [3:0] push_v,
                           output int pop_cnt, output int rdy_cyc);
        int n;
        res_cyc = 0; res_v = 0; err_cyc = 0; err_c = 0;
        push_cnt = 0; push_v = 0; pop_cnt = 0; rdy_cyc = 0;
        tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
        n = 0;
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) begin
            chk("ready_timeout", 0, 1);
            tok_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) tok_valid = 1'b0;
            if (res_valid) begin res_cyc = k; res_v = res_data; end
            if (err_valid) begin err_cyc = k; err_c = err_code; end
            if (stk_push) begin push_cnt++; push_v = stk_data_in; end
            if (stk_pop) pop_cnt++;
            if (tok_ready) begin rdy_cyc = k; break; end
        end
        if (rdy_cyc == 0) chk("token_done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tok_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: plain queue-based RPN evaluator.
    int mstk[$];

    task automatic tok_model(input bit is_op, input logic [3:0] d);
        int e_res_cyc, e_err_cyc, e_push, e_pop, e_rdy, a, b, r;
        int e_res, e_pushv, e_err;
        int rc, ec, pc, poc, rdy;
        logic [3:0] rv, pv;
        logic [1:0] ev;
        e_res_cyc = 0; e_err_cyc = 0; e_push = 0; e_pop = 0; e_rdy = 1;
        e_res = 0; e_pushv = 0; e_err = 0; r = 0;
        if (!is_op) begin
            if (mstk.size() == 8) begin e_err = 2; e_err_cyc = 1; end
            else begin mstk.push_back(int'(d)); e_push = 1; e_pushv = int'(d); e_rdy = 2; end
        end else if (d <= 4) begin
            if (mstk.size() < 2) begin e_err = 1; e_err_cyc = 1; end
            else begin
                b = mstk.pop_back();
                a = mstk.pop_back();
                case (d)
                    4'd0: r = a + b;
                    4'd1: r = a - b;
                    4'd2: r = a & b;
                    4'd3: r = a | b;
                    default: r = a ^ b;
                endcase
                r = (r + 16) % 16;
                mstk.push_back(r);
                e_res_cyc = 5; e_res = r; e_push = 1; e_pushv = r; e_pop = 2; e_rdy = 6;
            end
        end else if (d == 5) begin
            if (mstk.size() < 1) begin e_err = 1; e_err_cyc = 1; end
            else begin
                r = mstk.pop_back();
                e_res_cyc = 3; e_res = r; e_pop = 1; e_rdy = 4;
            end
        end else begin
            e_err = 3; e_err_cyc = 1;
        end
        run_tok(is_op, d, rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("rnd_res_cycle", rc, e_res_cyc);
        if (e_res_cyc != 0) chk("rnd_res_data", int'(rv), e_res);
        chk("rnd_err_cycle", ec, e_err_cyc);
        chk("rnd_err_code", int'(ev), e_err);
        chk("rnd_push_count", pc, e_push);
        if (e_push != 0) chk("rnd_push_data", int'(pv), e_pushv);
        chk("rnd_pop_count", poc, e_pop);
        chk("rnd_ready_cycle", rdy, e_rdy);
        chk("rnd_depth", int'(depth), mstk.size());
    endtask

    typedef struct {
        bit         is_op;
        logic [3:0] d;
        int         rcyc;   // 0 = no result expected
        logic [3:0] rval;
        logic [1:0] err;    // 0 = no error expected
        int         dep;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int rc, ec, pc, poc, rdy;
        logic [3:0] rv, pv;
        logic [1:0] ev;

        tbl[0]  = '{1'b0, 4'd3, 0, 4'd0,  2'd0, 1};
        tbl[1]  = '{1'b0, 4'd4, 0, 4'd0,  2'd0, 2};
        tbl[2]  = '{1'b1, 4'd0, 5, 4'd7,  2'd0, 1};
        tbl[3]  = '{1'b1, 4'd5, 3, 4'd7,  2'd0, 0};
        tbl[4]  = '{1'b0, 4'd2, 0, 4'd0,  2'd0, 1};
        tbl[5]  = '{1'b0, 4'd5, 0, 4'd0,  2'd0, 2};
        tbl[6]  = '{1'b1, 4'd1, 5, 4'd13, 2'd0, 1};
        tbl[7]  = '{1'b1, 4'd5, 3, 4'd13, 2'd0, 0};
        tbl[8]  = '{1'b1, 4'd0, 0, 4'd0,  2'd1, 0};
        tbl[9]  = '{1'b0, 4'd6, 0, 4'd0,  2'd0, 1};
        tbl[10] = '{1'b1, 4'd2, 0, 4'd0,  2'd1, 1};
        tbl[11] = '{1'b1, 4'd9, 0, 4'd0,  2'd3, 1};
        tbl[12] = '{1'b1, 4'd5, 3, 4'd6,  2'd0, 0};

        do_reset();
        chk("rst_depth", int'(depth), 0);
        chk("rst_ready", int'(tok_ready), 1);
        chk("rst_push", int'(stk_push), 0);
        chk("rst_pop", int'(stk_pop), 0);
        chk("rst_data_in", int'(stk_data_in), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_err_code", int'(err_code), 0);

        // Table-driven directed vectors
        for (int i = 0; i < 13; i++) begin
            run_tok(tbl[i].is_op, tbl[i].d, rc, rv, ec, ev, pc, pv, poc, rdy);
            chk($sformatf("tbl%0d_res_cycle", i), rc, tbl[i].rcyc);
            if (tbl[i].rcyc != 0) chk($sformatf("tbl%0d_res_data", i), int'(rv), int'(tbl[i].rval));
            chk($sformatf("tbl%0d_err_code", i), int'(ev), int'(tbl[i].err));
            if (tbl[i].err != 0) chk($sformatf("tbl%0d_err_cycle", i), ec, 1);
            if (!tbl[i].is_op && tbl[i].err == 0) begin
                chk($sformatf("tbl%0d_push_count", i), pc, 1);
                chk($sformatf("tbl%0d_push_data", i), int'(pv), int'(tbl[i].d));
            end
            chk($sformatf("tbl%0d_depth", i), int'(depth), tbl[i].dep);
        end

        // Overflow: fill with 1..8, then 9 is rejected
        for (int i = 1; i <= 8; i++)
            run_tok(1'b0, 4'(i), rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("fill_depth", int'(depth), 8);
        run_tok(1'b0, 4'd9, rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("ovf_err_code", int'(ev), 2);
        chk("ovf_err_cycle", ec, 1);
        chk("ovf_push_count", pc, 0);
        chk("ovf_depth", int'(depth), 8);
        for (int i = 0; i < 7; i++)
            run_tok(1'b1, 4'd4, rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("xor_depth", int'(depth), 1);
        run_tok(1'b1, 4'd5, rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("xor_out", int'(rv), 8);
        chk("xor_out_depth", int'(depth), 0);

        // tok_valid held high across a binary op; next token waits
        run_tok(1'b0, 4'd1, rc, rv, ec, ev, pc, pv, poc, rdy);
        run_tok(1'b0, 4'd2, rc, rv, ec, ev, pc, pv, poc, rdy);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin tok_is_op = 1'b0; tok_data = 4'd9; end
            chk($sformatf("hold_ready_k%0d", k), int'(tok_ready), int'(k == 6));
            if (k == 5) begin
                chk("hold_res_valid", int'(res_valid), 1);
                chk("hold_res_data", int'(res_data), 3);
            end
        end
        @(negedge clk);
        tok_valid = 1'b0;
        chk("hold_next_push", int'(stk_push), 1);
        chk("hold_next_data", int'(stk_data_in), 9);
        @(negedge clk);
        chk("hold_no_dup", int'(stk_push), 0);
        chk("hold_depth", int'(depth), 2);
        run_tok(1'b1, 4'd5, rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("hold_out1", int'(rv), 9);
        run_tok(1'b1, 4'd5, rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("hold_out2", int'(rv), 3);

        // Reset asserted while waiting for operand A
        run_tok(1'b0, 4'd1, rc, rv, ec, ev, pc, pv, poc, rdy);
        run_tok(1'b0, 4'd2, rc, rv, ec, ev, pc, pv, poc, rdy);
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 4'd0;
        @(negedge clk);
        tok_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_depth", int'(depth), 0);
        chk("mid_rst_push", int'(stk_push), 0);
        chk("mid_rst_res", int'(res_valid), 0);
        chk("mid_rst_ready", int'(tok_ready), 1);
        @(negedge clk);
        chk("mid_rst_push2", int'(stk_push), 0);
        chk("mid_rst_res2", int'(res_valid), 0);
        run_tok(1'b0, 4'd5, rc, rv, ec, ev, pc, pv, poc, rdy);
        run_tok(1'b1, 4'd5, rc, rv, ec, ev, pc, pv, poc, rdy);
        chk("mid_rst_out", int'(rv), 5);
        chk("mid_rst_out_depth", int'(depth), 0);

        // Randomized tokens against the queue model
        do_reset();
        mstk.delete();
        for (int i = 0; i < 400; i++) begin
            bit is_op;
            logic [3:0] d;
            is_op = ($urandom_range(0, 99) >= 55);
            if (!is_op)                        d = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(6, 15));
            else                               d = 4'($urandom_range(0, 5));
            tok_model(is_op, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Token-driven controller that sits directly upstream of the 8-deep x 4-bit LIFO stack. It drives the stack's push, pop and data_in, and consumes its data_out.
- Accepts a stream of operand and operator tokens over a valid/ready handshake and evaluates reverse-Polish expressions on the stack.
- Reports each arithmetic result and each error as a one-cycle pulse.
- Keeps its own occupancy count and never issues an illegal push or pop to the stack.

Parameters:
- W, 4, data/operand width; must equal stack width.
- DEPTH, 8, stack depth; must equal stack depth.
- CW, 4, occupancy counter width (holds 0..DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset. Same reset net as the stack.
- tok_valid  in  1  token present.
- tok_ready  out  1  controller can accept a token.
- tok_is_op  in  1  1 = tok_data is an opcode; 0 = tok_data is an operand.
- tok_data  in  W  operand value or opcode.
- stk_push  out  1  push strobe to stack.
- stk_pop  out  1  pop strobe to stack.
- stk_data_in  out  W  value to push.
- stk_data_out  in  W  stack output; valid in the cycle after the cycle in which stk_pop is high.
- res_valid  out  1  one-cycle result pulse.
- res_data  out  W  result value, held until the next result.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  01 underflow, 10 overflow, 11 illegal opcode; held until the next error.
- depth  out  CW  current occupancy count.

Behaviour:
- Reset values: state IDLE, count 0, stk_push 0, stk_pop 0, stk_data_in 0, res_valid 0, res_data 0, err_valid 0, err_code 00. tok_ready is 1 the first cycle after reset.
- A token is accepted on the rising edge where tok_valid & tok_ready. tok_ready = (state == IDLE).
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: binary. A = deeper operand, B = top.
  - 5 OUT: pop the top and report it, no push back.
  - 6..15: illegal.
- Arithmetic is mod 2^W. SUB = A - B with wrap, e.g. 2 - 5 = 13. No carry or borrow flag.
- Operand token:
  - If count == DEPTH: err_valid = 1, err_code = 10 in the next cycle. Stay in IDLE, no push.
  - Else: next state PUSH. stk_push = 1 and stk_data_in = operand for exactly one cycle, count + 1, then IDLE.
- Binary op, count < 2: err_code 01 pulse, no stack activity, stay IDLE.
- Binary op, count >= 2: IDLE -> POP_B -> WAIT_B -> POP_A -> WAIT_A -> PUSH_R -> IDLE.
  - POP_B, POP_A: stk_pop = 1.
  - WAIT_B: B captured from stk_data_out.
  - WAIT_A: A taken from stk_data_out; res_data registered as A op B at the end of this cycle.
  - PUSH_R: stk_push = 1, stk_data_in = res_data, res_valid = 1.
  - Count: net -1. Decrement at POP_B and POP_A, increment at PUSH_R.
  - Latency: res_valid high 5 cycles after the accepting edge. tok_ready high again the cycle after PUSH_R.
- OUT, count < 1: err_code 01 pulse, stay IDLE.
- OUT, count >= 1: IDLE -> POP_B -> WAIT_B -> RES -> IDLE.
  - res_data = popped value, registered at the end of WAIT_B.
  - res_valid = 1 in RES. Count - 1.
- Illegal opcode: err_code 11 pulse, no stack activity, count unchanged.
- Error checks are evaluated at the accepting edge. A rejected token is consumed (not retried); the next token can be accepted in the cycle following the error.
- stk_push and stk_pop are never high in the same cycle. Each is high for at most one cycle per stack operation.
- depth mirrors the internal count. Count never exceeds DEPTH and never goes below 0.
- tok_valid with tok_ready low: token ignored. The source must hold it until accepted.
- Reset mid-sequence: return to IDLE, count 0, all strobes low the next cycle. No partial push is completed. The stack is reset by the same signal, so the two stay consistent.
- No stack flags are inputs: underflow and overflow are judged from count alone.

Decomposition:
- Package rpn_pkg:
  - opcode constants OP_ADD..OP_OUT.
  - err-code constants ERR_UNDER, ERR_OVER, ERR_ILLEGAL.
  - state encoding IDLE, PUSH, POP_B, WAIT_B, POP_A, WAIT_A, PUSH_R, RES.
- Sub-module rpn_alu: combinational, inputs a, b, op; output y. Instanced once.
- FSM, count and handshake logic live in rpn_stack_ctrl.
- The bench instantiates rpn_stack_ctrl driving the real 8x4 stack.

Test Plan:
- Push 3, push 4, op ADD -> stk_push pulses carry 3 then 4; res_valid 5 cycles after the ADD accept with res_data = 7; depth 2 -> 1; OUT then gives res_data = 7, depth 0.
- Push 2, push 5, op SUB -> res_data = 13 (wrap); OUT -> 13.
- Push 1..8 (8 tokens), then push 9 -> err_valid with err_code 10, depth stays 8, no stk_push for 9; 7 consecutive XOR ops -> final OUT gives 8.
- After reset: op ADD -> err 01; push 6, op AND -> err 01, depth 1; opcode 9 -> err 11; OUT -> res_data 6.
- Hold tok_valid high continuously during a binary op -> tok_ready low for POP_B..PUSH_R; next token accepted the cycle after PUSH_R; no token lost or duplicated.
- Assert reset during WAIT_A -> next cycle state IDLE, depth 0, no stk_push/res_valid; subsequent push 5, OUT -> 5.
